divider: RTL and testbench

Multi-cycle 32-bit integer divider, the inverse of the ALU's multiply operations (ops 16–18). The core issues dividend, divisor and signedness with a one-cycle start pulse. The block runs a radix-2 restoring division and returns quotient, remainder and flags with a done pulse. It sits beside the ALU on the execute stage and stalls the core through `busy`.

---
 rtl/divider.sv | 174 +++++++++++++++++
 tb/tb_divider.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring integer divider (signed or unsigned).
//
// Ports:
//   clk         - clock; all state updates on the rising edge
//   reset       - synchronous, active-high reset
//   start       - request; accepted when start=1 and busy=0
//   a, b        - dividend / divisor, sampled on acceptance
//   is_signed   - 1: two's-complement division, 0: unsigned
//   busy        - high from the acceptance edge until the edge raising done
//   done        - one-cycle pulse; results valid from this cycle on
//   quotient    - result quotient, held until the next result
//   remainder   - result remainder (takes the dividend's sign)
//   div_zero    - last request had b=0
//   is_zero     - quotient == 0
//   is_negative - quotient MSB
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             is_zero,
  output logic             is_negative
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend, quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, rem_sub;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign b_zero = (b == '0);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Next-state logic. A zero divisor skips the iterations but still passes through
  // FIX, so busy is high for one cycle and done follows one cycle after acceptance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) state_d = b_zero ? StFix : StRun;
        else        state_d = StIdle;
      end
      StRun:   if (cnt_q == CntW'(1)) state_d = StFix;
      StFix:   state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // One bit wider than the operands: the shifted remainder can exceed WIDTH bits
    // when the divisor is close to 2^WIDTH.
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};

    if (accept) begin
      if (b_zero) begin
        // Raw passthrough; FIX then loads these unchanged since both signs are clear.
        dvd_d      = '1;
        rem_d      = a;
        dvs_d      = '0;
        neg_quot_d = 1'b0;
        neg_rem_d  = 1'b0;
        dz_d       = 1'b1;
      end else begin
        dvd_d      = a_mag;
        dvs_d      = b_mag;
        rem_d      = '0;
        cnt_d      = CntW'(WIDTH);
        neg_quot_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_d  = is_signed && a[WIDTH-1];
        dz_d       = 1'b0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (!rem_sub[WIDTH]) begin
            rem_d = rem_sub[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CntW'(1);
        end
        StFix: begin
          quotient_d  = neg_quot_q ? -dvd_q : dvd_q;
          remainder_d = neg_rem_q ? -rem_q : rem_q;
          div_zero_d  = dz_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy        = (state_q == StRun) || (state_q == StFix);
    done        = (state_q == StDone);
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_zero    = div_zero_q;
    is_zero     = (quotient_q == '0);
    is_negative = quotient_q[WIDTH-1];
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: vector table, random vectors against a
// behavioural model, and hand-written handshake / reset sequences.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        is_signed;
  logic        busy, done, div_zero, is_zero, is_negative;
  logic [31:0] quotient, remainder;

  divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .is_signed  (is_signed),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_zero   (div_zero),
    .is_zero    (is_zero),
    .is_negative(is_negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    int   sx, sy;
    if (y == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = x; e.dz = 1'b1;
    end else if (!s) begin
      e.q = x / y; e.r = x % y; e.dz = 1'b0;
    end else begin
      sx = x; sy = y;
      e.q = sx / sy; e.r = sx % sy; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
        chk("is_zero", {31'b0, is_zero}, {31'b0, (e.q == 32'd0)});
        chk("is_negative", {31'b0, is_negative}, {31'b0, e.q[31]});
        chk("busy_in_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  // Called just after a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isg,
                       input exp_t e, input int elat, input string tag);
    int          cyc, bcnt;
    logic [31:0] q0, r0;
    logic        stable;
    a = ia; b = ib; is_signed = isg; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    cyc = 0; bcnt = 0; q0 = quotient; r0 = remainder; stable = 1'b1;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      if (quotient !== q0 || remainder !== r0) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(elat));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(elat));
    chk({tag, "_hold_while_busy"}, {31'b0, stable}, 32'd1);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] x, y;
    logic        s;
    int          cyc, dcnt;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    vecs[2]  = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0};
    vecs[3]  = '{32'h1234,      32'd0,         1'b0, 32'hFFFFFFFF,  32'h1234,      1'b1};
    vecs[4]  = '{32'h1234,      32'd0,         1'b1, 32'hFFFFFFFF,  32'h1234,      1'b1};
    vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0};
    vecs[6]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[7]  = '{32'd5,         32'd9,         1'b0, 32'd0,         32'd5,         1'b0};
    vecs[8]  = '{32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, 32'd1,         32'd1,         1'b0};
    vecs[9]  = '{32'h80000000,  32'd2,         1'b1, 32'hC0000000,  32'd0,         1'b0};
    vecs[10] = '{32'hFFFFFFF9,  32'd2,         1'b0, 32'h7FFFFFFC,  32'd1,         1'b0};
    vecs[11] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'd1,         32'd0,         1'b0};

    // Reset values
    reset = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
    chk("rst_is_zero", {31'b0, is_zero}, 32'd1);
    chk("rst_is_negative", {31'b0, is_negative}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table, each started from IDLE
    for (int i = 0; i < 12; i++) begin
      e.q = vecs[i].q; e.r = vecs[i].r; e.dz = vecs[i].dz;
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, e, vecs[i].dz ? 1 : 33, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Random vectors against the model, issued back-to-back in the done cycle
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      s = 1'($urandom_range(0, 1));
      if (s && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd3;
      e = model(x, y, s);
      do_op(x, y, s, e, (y == 32'd0) ? 1 : 33, $sformatf("rnd%0d", i));
    end
    @(negedge clk);

    // start while busy is ignored
    a = 32'd1000; b = 32'd10; is_signed = 1'b0; start = 1'b1;
    e.q = 32'd100; e.r = 32'd0; e.dz = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      if (cyc == 10) begin
        start = 1'b1; a = 32'd9; b = 32'd3; is_signed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("ignore_start_latency", 32'(cyc), 32'd33);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("ignore_start_no_extra_done", 32'(dcnt), 32'd0);

    // Back-to-back: second start in the done cycle
    e.q = 32'd3; e.r = 32'd1; e.dz = 1'b0;
    do_op(32'd10, 32'd3, 1'b0, e, 33, "b2b_first");
    e.q = 32'hFFFFFFFB; e.r = 32'hFFFFFFFF; e.dz = 1'b0;
    do_op(32'hFFFFFFF5, 32'd2, 1'b1, e, 33, "b2b_second");
    @(negedge clk);

    // Reset mid-operation, with start asserted on the reset edge
    a = 32'd12345; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    e.q = 32'd1763; e.r = 32'd4; e.dz = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 32'd50; b = 32'd5;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_div_zero", {31'b0, div_zero}, 32'd0);
    chk("midrst_is_zero", {31'b0, is_zero}, 32'd1);
    reset = 1'b0; start = 1'b0;
    sb.delete();
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    e.q = 32'd1763; e.r = 32'd4; e.dz = 1'b0;
    do_op(32'd12345, 32'd7, 1'b0, e, 33, "after_rst");
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

endmodule
